// File: rtl/vote_qualifier_multi.sv
// N-channel vote qualifier: synchronises raw panel buttons, qualifies stable
// presses, arbitrates simultaneous qualifiers and applies a post-vote lockout.

// Per-channel synchroniser + press/release qualification FSM.
// qual is combinational from registered state only (synced button, counters);
// the channel moves itself to WAIT_REL on qualifying, whether or not the
// top-level arbiter accepts the vote.
module vote_qualifier_chan #(
  parameter int HOLD_CYCLES = 10,
  localparam int CW = $clog2(HOLD_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  input  logic vote_en,
  input  logic lockout,
  output logic qual
);
  typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} st_t;

  // cnt holds the number of samples already seen, so the current sample is
  // the last one needed when cnt == HOLD_CYCLES-1.
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [1:0]    sync;
  logic          s;
  st_t           state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  assign s = sync[1];

  // Two-flop synchroniser for the asynchronous pad input.
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync <= '0;
    else        sync <= {sync[0], button};

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end

  // Next-state: stable press to qualify, stable release to re-arm.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    qual      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (s && !lockout && vote_en) begin
          if (HOLD_CYCLES == 1) begin
            qual      = 1'b1;
            state_nxt = WAIT_REL;
          end else begin
            state_nxt = HOLD;
            cnt_nxt   = CW'(1);
          end
        end
      end
      HOLD: begin
        if (!vote_en || !s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          qual      = 1'b1;
          state_nxt = WAIT_REL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      WAIT_REL: begin
        if (s) begin
          cnt_nxt = '0;
        end else if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end
endmodule

module vote_qualifier_multi #(
  parameter int N_CH           = 4,
  parameter int HOLD_CYCLES    = 10,
  parameter int LOCKOUT_CYCLES = 16,
  localparam int IDW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vote_en,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] valid_vote,
  output logic            vote_strobe,
  output logic [IDW-1:0]  vote_id,
  output logic            multi_err,
  output logic            lockout
);
  localparam int LCW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

  logic [N_CH-1:0] qual;
  logic            single, multi;
  logic [IDW-1:0]  qual_id;
  logic [LCW-1:0]  lock_cnt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    vote_qualifier_chan #(.HOLD_CYCLES(HOLD_CYCLES)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .button  (button[i]),
      .vote_en (vote_en),
      .lockout (lockout),
      .qual    (qual[i])
    );
  end

  assign lockout = (lock_cnt != '0);

  // Arbitration: exactly one qualifier wins, two or more are all rejected.
  always_comb begin
    single  = (qual != '0) && ((qual & (qual - N_CH'(1))) == '0);
    multi   = (qual != '0) && !single;
    qual_id = '0;
    for (int i = 0; i < N_CH; i++)
      if (qual[i]) qual_id = IDW'(i);
  end

  // Registered outputs and lockout countdown (reloaded by each accepted vote).
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid_vote  <= '0;
      vote_strobe <= 1'b0;
      vote_id     <= '0;
      multi_err   <= 1'b0;
      lock_cnt    <= '0;
    end else begin
      valid_vote  <= single ? qual : '0;
      vote_strobe <= single;
      multi_err   <= multi;
      if (single) vote_id <= qual_id;
      if (single)               lock_cnt <= LCW'(LOCKOUT_CYCLES);
      else if (lock_cnt != '0)  lock_cnt <= lock_cnt - LCW'(1);
    end
endmodule

// File: tb/tb_vote_qualifier_multi.sv
// Bench for vote_qualifier_multi (N_CH=4, HOLD_CYCLES=4, LOCKOUT_CYCLES=8).
// Expected pulses are queued when stimulus is driven; a negedge monitor pops
// them on their due edge and compares every output every cycle.
module tb_vote_qualifier_multi;
  localparam int N = 4, H = 4, L = 8;

  logic       clk = 0, reset = 0, vote_en = 1;
  logic [3:0] button = '0;
  logic [3:0] valid_vote;
  logic       vote_strobe, multi_err, lockout;
  logic [1:0] vote_id;

  vote_qualifier_multi #(.N_CH(N), .HOLD_CYCLES(H), .LOCKOUT_CYCLES(L)) dut (
    .clk(clk), .reset(reset), .vote_en(vote_en), .button(button),
    .valid_vote(valid_vote), .vote_strobe(vote_strobe), .vote_id(vote_id),
    .multi_err(multi_err), .lockout(lockout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int edge_n; logic [3:0] vv; logic me; } ev_t;
  ev_t q[$];

  typedef struct {
    logic [3:0] mask;
    int hold1, gap, hold2;
    int ev0; logic [3:0] vv0; logic me0;
    int ev1; logic [3:0] vv1;
  } vec_t;

  int n_chk = 0, n_pass = 0;
  logic       mon_en = 0;
  logic [1:0] exp_id = '0;
  int         lk = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  task automatic push(int e, logic [3:0] vv, logic me);
    ev_t ev;
    ev.edge_n = e; ev.vv = vv; ev.me = me;
    q.push_back(ev);
  endtask

  // Monitor: compare all outputs against queued expectations each cycle.
  always @(negedge clk) begin
    logic [3:0] evv;
    logic       eme;
    if (reset && mon_en) begin
      evv = '0; eme = 1'b0;
      if (q.size() > 0 && q[0].edge_n == cyc) begin
        evv = q[0].vv; eme = q[0].me;
        void'(q.pop_front());
      end
      if (evv != '0) begin
        for (int i = 0; i < 4; i++) if (evv[i]) exp_id = 2'(i);
        lk = L;
      end
      chk("valid_vote", 32'(valid_vote), 32'(evv));
      chk("vote_strobe", 32'(vote_strobe), 32'(evv != '0));
      chk("multi_err", 32'(multi_err), 32'(eme));
      chk("vote_id", 32'(vote_id), 32'(exp_id));
      chk("lockout", 32'(lockout), 32'(lk != 0));
      if (lk > 0) lk--;
    end
  end

  task automatic quiet(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    int e0, p;
    vecs[0] = '{4'b0100, 20, 0, 0,  5, 4'b0100, 1'b0, -1, 4'b0000}; // single vote + lockout
    vecs[1] = '{4'b0010,  3, 2, 3, -1, 4'b0000, 1'b0, -1, 4'b0000}; // glitchy presses
    vecs[2] = '{4'b1001, 20, 0, 0,  5, 4'b0000, 1'b1, -1, 4'b0000}; // simultaneous -> multi_err
    vecs[3] = '{4'b0100, 15, 4, 8,  5, 4'b0100, 1'b0, 24, 4'b0100}; // re-arm after 4 low
    vecs[4] = '{4'b0100, 15, 3, 8,  5, 4'b0100, 1'b0, -1, 4'b0000}; // release too short
    vecs[5] = '{4'b1000,  4, 0, 0,  5, 4'b1000, 1'b0, -1, 4'b0000}; // minimum hold
    vecs[6] = '{4'b0001,  3, 0, 0, -1, 4'b0000, 1'b0, -1, 4'b0000}; // one short of hold
    vecs[7] = '{4'b0001,  4, 0, 0,  5, 4'b0001, 1'b0, -1, 4'b0000};

    // Reset state.
    #2;
    chk("rst valid_vote", 32'(valid_vote), 0);
    chk("rst vote_strobe", 32'(vote_strobe), 0);
    chk("rst vote_id", 32'(vote_id), 0);
    chk("rst multi_err", 32'(multi_err), 0);
    chk("rst lockout", 32'(lockout), 0);
    repeat (3) @(posedge clk);
    #2 reset = 1;
    mon_en = 1;
    quiet(5);

    // Table-driven scenarios.
    foreach (vecs[k]) begin
      e0 = cyc + 1;
      if (vecs[k].ev0 >= 0) push(e0 + vecs[k].ev0, vecs[k].vv0, vecs[k].me0);
      if (vecs[k].ev1 >= 0) push(e0 + vecs[k].ev1, vecs[k].vv1, 1'b0);
      button = vecs[k].mask;
      quiet(vecs[k].hold1);
      button = '0;
      if (vecs[k].hold2 > 0) begin
        quiet(vecs[k].gap);
        button = vecs[k].mask;
        quiet(vecs[k].hold2);
        button = '0;
      end
      quiet(30);
      chk("pending events", 32'(q.size()), 0);
    end

    // Press during lockout: HOLD begins only once lockout clears.
    e0 = cyc + 1;
    push(e0 + 5, 4'b0100, 1'b0);
    push(e0 + 17, 4'b0010, 1'b0);
    button = 4'b0100;
    quiet(7);
    button = 4'b0110;
    quiet(14);
    button = '0;
    quiet(30);
    chk("pending lockout seq", 32'(q.size()), 0);

    // Async reset while in HOLD: press discarded, re-qualifies from IDLE.
    button = 4'b0010;
    repeat (5) @(posedge clk);
    #2 reset = 0;
    exp_id = '0; lk = 0;
    #1;
    chk("rst-hold valid_vote", 32'(valid_vote), 0);
    chk("rst-hold vote_id", 32'(vote_id), 0);
    chk("rst-hold lockout", 32'(lockout), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1;
    p = cyc;
    push(p + 6, 4'b0010, 1'b0);
    quiet(8);
    button = '0;
    quiet(30);
    chk("pending reset-hold", 32'(q.size()), 0);

    // vote_en dropped in HOLD: no vote; re-qualifies once enabled again.
    e0 = cyc + 1;
    button = 4'b1000;
    repeat (5) @(posedge clk);
    #1 vote_en = 0;
    repeat (2) @(posedge clk);
    #1 vote_en = 1;
    push(e0 + 10, 4'b1000, 1'b0);
    quiet(6);
    button = '0;
    quiet(30);
    chk("pending vote_en", 32'(q.size()), 0);

    // Async reset during the vote pulse truncates every output at once.
    e0 = cyc + 1;
    push(e0 + 5, 4'b0100, 1'b0);
    button = 4'b0100;
    repeat (6) @(posedge clk);
    #6 reset = 0;
    exp_id = '0; lk = 0;
    button = '0;
    #1;
    chk("trunc valid_vote", 32'(valid_vote), 0);
    chk("trunc vote_strobe", 32'(vote_strobe), 0);
    chk("trunc vote_id", 32'(vote_id), 0);
    chk("trunc lockout", 32'(lockout), 0);
    chk("pending trunc", 32'(q.size()), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1;
    quiet(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
